neuron_mac_seq: RTL

Sequencer and multiply-accumulate engine for one ANN neuron, sitting directly downstream of a per-neuron weight BRAM (28 × 16-bit, negedge-read) and its matching activation buffer. On START it walks addresses 0..N_IN-1 on both memories and accumulates weight × activation on top of a bias. It then emits one saturated, optionally ReLU-clamped 16-bit result with a valid/ready handshake. One instance per neuron; the outputs feed the next layer's activation buffer.

---
 rtl/neuron_mac_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/neuron_mac_seq.sv
// rtl/neuron_mac_seq.sv - neuron multiply-accumulate sequencer
// Walks both memories once per START and emits one saturated result with a valid/ready handshake.
module neuron_mac_seq #(
  parameter int N_IN   = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int RELU   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  output logic              BUSY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_EN,
  input  logic [DATA_W-1:0] W_DO,
  input  logic [DATA_W-1:0] X_DO,
  output logic [DATA_W-1:0] DOUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_OUT} state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      en_q, en_d;
  logic                      busy_q, busy_d;
  logic [DATA_W-1:0]         dout_q, dout_d;
  logic                      valid_q, valid_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    shifted;
  logic [DATA_W-1:0]          result;

  always_comb begin
    prod     = $signed(W_DO) * $signed(X_DO);
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_ext = $signed({{(ACC_W-DATA_W){BIAS[DATA_W-1]}}, BIAS}) <<< FRAC;
    shifted  = acc_q >>> FRAC;
    // Saturate first, then the optional ReLU clamp on the in-range value.
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      result = (RELU != 0) ? '0 : SAT_MIN[DATA_W-1:0];
    end else if ((RELU != 0) && shifted[ACC_W-1]) begin
      result = '0;
    end else begin
      result = shifted[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = en_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    if (valid_q && OUT_READY) begin
      valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (START && !valid_q) begin
          acc_d   = bias_ext;
          addr_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = (N_IN == 1) ? S_LAST : S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q + prod_ext;
        if (addr_q < ADDR_LAST) begin
          addr_d = addr_q + 1'b1;
        end
        // Once the last address is issued, its product arrives in LAST.
        if (addr_d == ADDR_LAST) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        acc_d   = acc_q + prod_ext;
        en_d    = 1'b0;
        state_d = S_OUT;
      end
      S_OUT: begin
        dout_d  = result;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
    end
  end

  assign MEM_ADDR  = addr_q;
  assign MEM_EN    = en_q;
  assign BUSY      = busy_q;
  assign DOUT      = dout_q;
  assign OUT_VALID = valid_q;

endmodule
